// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared types and defaults for the register write-back stage.
//   wb_state_t : write sequencer states (IDLE, WRITE, HOLD)
//   wb_src_t   : request source, used for round-robin arbitration
//   reg_onehot : one-hot register-enable decode of a register address
package reg_wb_pkg;

    localparam int NREGS_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } wb_state_t;

    typedef enum logic {
        SRC_ALU,
        SRC_LD
    } wb_src_t;

    function automatic logic [NREGS_DEF-1:0] reg_onehot(input logic [ADDR_W_DEF-1:0] addr);
        logic [NREGS_DEF-1:0] dec;
        dec       = '0;
        dec[addr] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/reg_wb_fifo.sv
// reg_wb_fifo: synchronous FIFO of {addr, data} register writes.
//   push/push_addr/push_data : enqueue (ignored while full)
//   pop                      : dequeue head (ignored while empty)
//   head_addr/head_data      : current head entry
//   count/full/empty         : registered occupancy and flags
//   entry_valid/entry_addrs  : per-slot valid mask and flat address view,
//                              used by the hazard lookup
module reg_wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [ADDR_W-1:0]         push_addr,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [ADDR_W-1:0]         head_addr,
    output logic [DATA_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH*ADDR_W-1:0]   entry_addrs
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observed
    // through count/entry_valid, which are reset, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    // NOTE: every variable driven here gets a default first so no latch is
    // inferred on any path through the loop.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        entry_addrs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset                         = PTR_W'(i) - rd_ptr;
            entry_valid[i]                 = ((PTR_W+1)'(offset) < count);
            entry_addrs[i*ADDR_W +: ADDR_W] = addr_mem[i];
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-back stage driving a level-sensitive register array.
//   alu_* / ld_*   : valid/ready write request groups (addr, data)
//   wr_en/wr_data  : one-hot register enable and shared data bus; data is set
//                    with the enable pulse and held through the following
//                    HOLD cycle, so one write completes every two cycles
//   chk_addr/chk_hit : hazard lookup, combinational
//   busy           : writes buffered or a write sequence in progress
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [NREGS-1:0]  wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_hit,
    output logic              busy
);

    wb_state_t                state;
    wb_src_t                  last;
    logic [ADDR_W-1:0]        cur_addr;

    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic [DEPTH-1:0]         entry_valid;
    logic [DEPTH*ADDR_W-1:0]  entry_addrs;

    logic                     alu_acc;
    logic                     ld_acc;
    logic                     push;
    logic [ADDR_W-1:0]        push_addr;
    logic [DATA_W-1:0]        push_data;
    logic                     pop;

    // Round-robin: a path yields only when the other path is requesting and
    // it was the last one served. Neither ready looks at its own valid.
    assign alu_ready = !full && (!ld_valid  || last == SRC_LD);
    assign ld_ready  = !full && (!alu_valid || last == SRC_ALU);
    assign alu_acc   = alu_valid && alu_ready;
    assign ld_acc    = ld_valid && ld_ready;

    assign push_addr = ld_acc ? ld_addr : alu_addr;
    assign push_data = ld_acc ? ld_data : alu_data;
    // Writes to r0 complete the handshake but are dropped here.
    assign push      = (alu_acc || ld_acc) && (push_addr != '0);
    // A new write may start from IDLE or straight out of HOLD.
    assign pop       = (state != WRITE) && !empty;

    reg_wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (push_addr),
        .push_data   (push_data),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entry_addrs (entry_addrs)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= SRC_ALU;
            cur_addr <= '0;
            wr_en    <= '0;
            wr_data  <= '0;
        end else begin
            if (ld_acc)       last <= SRC_LD;
            else if (alu_acc) last <= SRC_ALU;

            case (state)
                IDLE, HOLD: begin
                    if (pop) begin
                        state    <= WRITE;
                        cur_addr <= head_addr;
                        wr_data  <= head_data;
                        wr_en    <= NREGS'(reg_onehot(ADDR_W_DEF'(head_addr)));
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    state <= HOLD;
                    wr_en <= '0;
                end
                default: begin
                    state <= IDLE;
                    wr_en <= '0;
                end
            endcase
        end
    end

    // The HOLD address is excluded: that register has already been written.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_addrs[i*ADDR_W +: ADDR_W] == chk_addr)
                hit = 1'b1;
        end
        if (state == WRITE && cur_addr == chk_addr)
            hit = 1'b1;
        chk_hit = hit && (chk_addr != '0);
    end

    assign busy = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed and randomized bench for reg_writeback with a
// transaction-level reference model (queue of pending writes plus the time
// since the last write started).
module tb_reg_writeback;
    import reg_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_addr, ld_addr, chk_addr;
    logic [31:0] alu_data, ld_data;
    logic [31:0] wr_en, wr_data;
    logic        chk_hit, busy;

    reg_writeback #(
        .NREGS (32), .ADDR_W (5), .DATA_W (32), .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         mq[$];        // accepted writes not yet started
    wb_src_t     m_last;
    int          m_since;      // edges since the last write started (saturates at 3)
    logic [4:0]  m_cur_addr;
    logic [31:0] m_wr_data;
    bit          m_ok = 0;
    bit          m_acc_ld, m_acc_alu;
    wb_src_t     grants[$];
    int          obs[$];       // register indices seen pulsing on wr_en

    function automatic bit m_full();
        return mq.size() == DEPTH;
    endfunction

    function automatic bit exp_ld_ready();
        return !m_full() && (!alu_valid || m_last == SRC_ALU);
    endfunction

    function automatic bit exp_alu_ready();
        return !m_full() && (!ld_valid || m_last == SRC_LD);
    endfunction

    function automatic bit exp_chk();
        bit h = 0;
        if (chk_addr == 5'd0) return 0;
        foreach (mq[i]) if (mq[i].addr == chk_addr) h = 1;
        if (m_since == 0 && m_cur_addr == chk_addr) h = 1;
        return h;
    endfunction

    function automatic bit m_idle();
        return mq.size() == 0 && m_since >= 2;
    endfunction

    initial forever begin
        wr_t h;
        bit  lr, ar;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_last     = SRC_ALU;
            m_since    = 3;
            m_cur_addr = '0;
            m_wr_data  = '0;
            m_acc_ld   = 0;
            m_acc_alu  = 0;
            m_ok       = 1;
        end else if (m_ok) begin
            lr        = exp_ld_ready();
            ar        = exp_alu_ready();
            m_acc_ld  = ld_valid && lr;
            m_acc_alu = alu_valid && ar;
            // A write may start whenever one is pending and none started last edge.
            if (mq.size() > 0 && m_since >= 1) begin
                h          = mq.pop_front();
                m_cur_addr = h.addr;
                m_wr_data  = h.data;
                m_since    = 0;
            end else if (m_since < 3) begin
                m_since++;
            end
            if (m_acc_ld) begin
                if (ld_addr != 5'd0) mq.push_back('{addr: ld_addr, data: ld_data});
                m_last = SRC_LD;
                grants.push_back(SRC_LD);
            end else if (m_acc_alu) begin
                if (alu_addr != 5'd0) mq.push_back('{addr: alu_addr, data: alu_data});
                m_last = SRC_ALU;
                grants.push_back(SRC_ALU);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [31:0] exp_en;
        @(negedge clk);
        if (m_ok) begin
            exp_en = (m_since == 0) ? (32'h1 << m_cur_addr) : 32'h0;
            check("alu_ready", 32'(alu_ready), 32'(exp_alu_ready()));
            check("ld_ready",  32'(ld_ready),  32'(exp_ld_ready()));
            check("wr_en",     wr_en,          exp_en);
            check("wr_data",   wr_data,        m_wr_data);
            check("busy",      32'(busy),      32'(mq.size() > 0 || m_since <= 1));
            check("chk_hit",   32'(chk_hit),   32'(exp_chk()));
            for (int i = 0; i < 32; i++) if (wr_en[i]) obs.push_back(i);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while (!m_idle() && n < 200) begin
            step();
            n++;
        end
        check("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  li, ai;
        bit  saw_stall, done;

        rst_n = 1'b0; alu_valid = 0; ld_valid = 0;
        alu_addr = '0; ld_addr = '0; alu_data = '0; ld_data = '0; chk_addr = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_wr_en",     wr_en,            32'h0);
        check("rst_wr_data",   wr_data,          32'h0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_alu_ready", 32'(alu_ready),   32'd1);
        check("rst_ld_ready",  32'(ld_ready),    32'd1);
        check("rst_chk_hit",   32'(chk_hit),     32'd0);

        // Single ALU write, addr 5.
        wait_idle();
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        @(posedge clk); #2 alu_valid = 0;
        @(negedge clk);
        check("single_e0_wr_en", wr_en, 32'h0);
        check("single_e0_busy",  32'(busy), 32'd1);
        @(negedge clk);
        check("single_e1_wr_en",   wr_en,   32'h00000020);
        check("single_e1_wr_data", wr_data, 32'hDEADBEEF);
        @(negedge clk);
        check("single_e2_wr_en",   wr_en,   32'h0);
        check("single_e2_wr_data", wr_data, 32'hDEADBEEF);
        @(negedge clk);
        check("single_e3_wr_data", wr_data, 32'hDEADBEEF);
        check("single_e3_busy",    32'(busy), 32'd0);

        // Both paths contending: grants alternate starting with LD.
        wait_idle();
        grants.delete(); obs.delete();
        li = 0; ai = 0;
        for (int c = 0; c < 200 && (li < 6 || ai < 6); c++) begin
            ld_valid  = (li < 6); ld_addr  = 5'(1 + 2*li); ld_data  = $urandom;
            alu_valid = (ai < 6); alu_addr = 5'(2 + 2*ai); alu_data = $urandom;
            step();
            if (m_acc_ld)  li++;
            if (m_acc_alu) ai++;
        end
        ld_valid = 0; alu_valid = 0;
        wait_idle();
        check("rr_writes", 32'(obs.size()), 32'd12);
        for (int i = 0; i < 12 && i < grants.size() && i < obs.size(); i++) begin
            check($sformatf("rr_grant%0d", i), 32'(grants[i]),
                  (i % 2 == 0) ? 32'(SRC_LD) : 32'(SRC_ALU));
            check($sformatf("rr_order%0d", i), 32'(obs[i]), 32'(i + 1));
        end

        // Eight back-to-back loads: buffer fills and back-pressures.
        obs.delete(); saw_stall = 0; li = 0;
        for (int c = 0; c < 200 && li < 8; c++) begin
            ld_valid = 1; ld_addr = 5'(8 + li); ld_data = $urandom;
            @(negedge clk);
            if (!ld_ready) saw_stall = 1;
            step();
            if (m_acc_ld) li++;
        end
        ld_valid = 0;
        wait_idle();
        check("ld_burst_stall", 32'(saw_stall), 32'd1);
        check("ld_burst_count", 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs.size(); i++)
            check($sformatf("ld_burst_order%0d", i), 32'(obs[i]), 32'(8 + i));

        // Write to r0 is swallowed.
        alu_valid = 1; alu_addr = 5'd0; alu_data = 32'h12345678;
        @(negedge clk);
        check("r0_ready", 32'(alu_ready), 32'd1);
        @(posedge clk); #2 alu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r0_wr_en", wr_en, 32'h0);
            check("r0_busy",  32'(busy), 32'd0);
        end

        // Hazard lookup with two writes to r7.
        wait_idle();
        ld_valid = 1; ld_addr = 5'd7; ld_data = 32'hA0A0A0A0; chk_addr = 5'd7;
        @(negedge clk);
        check("hit_before", 32'(chk_hit), 32'd0);
        @(posedge clk); #2 ld_data = 32'hB1B1B1B1;
        @(negedge clk);
        check("hit_e0", 32'(chk_hit), 32'd1);
        @(posedge clk); #2 ld_valid = 0;
        @(negedge clk);
        check("hit_e1", 32'(chk_hit), 32'd1);
        @(negedge clk);
        check("hit_e2", 32'(chk_hit), 32'd1);
        @(negedge clk);
        check("hit_e3", 32'(chk_hit), 32'd1);
        check("hit_e3_data", wr_data, 32'hB1B1B1B1);
        @(negedge clk);
        check("hit_e4", 32'(chk_hit), 32'd0);
        chk_addr = 5'd0;

        // Reset while in WRITE with three writes buffered.
        wait_idle();
        li = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            ld_valid = 1; ld_addr = 5'(16 + li); ld_data = $urandom;
            step();
            if (m_acc_ld) li++;
            if (m_since == 0 && mq.size() == 3) done = 1;
        end
        check("mid_reset_reached", 32'(done), 32'd1);
        ld_valid = 0; rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        obs.delete();
        @(negedge clk);
        check("mid_reset_wr_en",   wr_en,      32'h0);
        check("mid_reset_wr_data", wr_data,    32'h0);
        check("mid_reset_busy",    32'(busy),  32'd0);
        repeat (20) @(negedge clk);
        check("mid_reset_no_writes", 32'(obs.size()), 32'd0);

        // Randomized traffic with occasional resets.
        step();
        for (int c = 0; c < 800; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            alu_valid = 1'($urandom_range(0, 1));
            ld_valid  = 1'($urandom_range(0, 1));
            alu_addr  = 5'($urandom_range(0, 7));
            ld_addr   = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            ld_data   = $urandom;
            chk_addr  = 5'($urandom_range(0, 7));
            step();
        end
        rst_n = 1'b1; alu_valid = 0; ld_valid = 0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
